// File: rtl/wb_mgmt_mailbox_pkg.sv
// Register map and bit positions shared by the management mailbox block.
package wb_mgmt_mailbox_pkg;
  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_H2C     = 8'h08;
  localparam logic [7:0] OFF_C2H     = 8'h0C;
  localparam logic [7:0] OFF_ERR_CLR = 8'h10;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int ST_H2C_FULL  = 0;
  localparam int ST_H2C_EMPTY = 1;
  localparam int ST_C2H_FULL  = 2;
  localparam int ST_C2H_EMPTY = 3;
  localparam int ST_H2C_OVF   = 4;
  localparam int ST_C2H_UDF   = 5;
  localparam int ST_H2C_CNT   = 8;
  localparam int ST_C2H_CNT   = 16;
endpackage

// File: rtl/wb_mgmt_mailbox_if.sv
// Wishbone classic slave bus between the management SoC and the mailbox.
interface wb_mgmt_mailbox_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  input  wbs_ack_o, wbs_dat_o);
  modport slave  (input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/wb_mgmt_mailbox_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push/pop are gated by full/empty here.
module mbox_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  r_wr, r_rd;
  logic [DEPTH-1:0][WIDTH-1:0]  r_mem;
  logic                         w_push, w_pop;

  assign full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign empty  = (r_wr == r_rd);
  assign count  = r_wr - r_rd;
  assign dout   = r_mem[r_rd[AW-1:0]];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage is cleared so the head output reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_mem <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= din;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/wb_mgmt_mailbox.sv
// Management Wishbone slave: core reset/IRQ control plus H2C/C2H mailbox FIFOs.
module wb_mgmt_mailbox
  import wb_mgmt_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  wb_mgmt_mailbox_if.slave     wbs,
  output logic [31:0]          h2c_data_o,
  output logic                 h2c_valid_o,
  input  logic                 h2c_ready_i,
  input  logic [31:0]          c2h_data_i,
  input  logic                 c2h_valid_i,
  output logic                 c2h_ready_o,
  output logic                 core_rst_no,
  output logic                 irq_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic        r_ack, r_irq, r_ovf, r_udf;
  logic [31:0] r_dat;
  logic [1:0]  r_ctrl;

  logic          w_hit, w_acc, w_wr, w_rd;
  logic [7:0]    w_off;
  logic          w_h2c_full, w_h2c_empty, w_c2h_full, w_c2h_empty;
  logic [CW-1:0] w_h2c_cnt, w_c2h_cnt;
  logic [31:0]   w_c2h_dout, w_status, w_rdata;
  logic          w_h2c_push, w_c2h_pop, w_errclr;
  logic          w_unused;

  // An access is accepted only while ack is low, giving one ack per two cycles.
  assign w_hit      = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_acc      = wbs.wbs_cyc_i & wbs.wbs_stb_i & w_hit & ~r_ack;
  assign w_off      = {wbs.wbs_adr_i[7:2], 2'b00};
  assign w_wr       = w_acc & wbs.wbs_we_i;
  assign w_rd       = w_acc & ~wbs.wbs_we_i;
  assign w_h2c_push = w_wr && (w_off == OFF_H2C);
  assign w_c2h_pop  = w_rd && (w_off == OFF_C2H);
  assign w_errclr   = w_wr && (w_off == OFF_ERR_CLR);
  assign w_unused   = ^{wbs.wbs_sel_i[3:1], wbs.wbs_adr_i[1:0]};

  mbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_h2c (
    .clk(wb_clk_i), .rst_n(wb_rst_ni),
    .push(w_h2c_push), .din(wbs.wbs_dat_i), .pop(h2c_ready_i),
    .dout(h2c_data_o), .full(w_h2c_full), .empty(w_h2c_empty), .count(w_h2c_cnt)
  );

  mbox_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_c2h (
    .clk(wb_clk_i), .rst_n(wb_rst_ni),
    .push(c2h_valid_i), .din(c2h_data_i), .pop(w_c2h_pop),
    .dout(w_c2h_dout), .full(w_c2h_full), .empty(w_c2h_empty), .count(w_c2h_cnt)
  );

  assign h2c_valid_o = ~w_h2c_empty;
  assign c2h_ready_o = ~w_c2h_full;
  assign core_rst_no = r_ctrl[CTRL_RUN];
  assign irq_o       = r_irq;
  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;

  always_comb begin
    w_status                    = '0;
    w_status[ST_H2C_FULL]       = w_h2c_full;
    w_status[ST_H2C_EMPTY]      = w_h2c_empty;
    w_status[ST_C2H_FULL]       = w_c2h_full;
    w_status[ST_C2H_EMPTY]      = w_c2h_empty;
    w_status[ST_H2C_OVF]        = r_ovf;
    w_status[ST_C2H_UDF]        = r_udf;
    w_status[ST_H2C_CNT +: 4]   = 4'(w_h2c_cnt);
    w_status[ST_C2H_CNT +: 4]   = 4'(w_c2h_cnt);
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_CTRL:   w_rdata = {30'b0, r_ctrl};
      OFF_STATUS: w_rdata = w_status;
      OFF_C2H:    w_rdata = w_c2h_empty ? 32'h0 : w_c2h_dout;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_ctrl <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_rd ? w_rdata : 32'h0;
      r_irq <= r_ctrl[CTRL_IRQ_EN] & ~w_c2h_empty;
      if (w_wr && (w_off == OFF_CTRL) && wbs.wbs_sel_i[0])
        r_ctrl <= wbs.wbs_dat_i[1:0];
      if (w_h2c_push && w_h2c_full)               r_ovf <= 1'b1;
      else if (w_errclr && wbs.wbs_dat_i[ST_H2C_OVF]) r_ovf <= 1'b0;
      if (w_c2h_pop && w_c2h_empty)               r_udf <= 1'b1;
      else if (w_errclr && wbs.wbs_dat_i[ST_C2H_UDF]) r_udf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_mgmt_mailbox.sv
// Directed bench for wb_mgmt_mailbox with a queue-based reference model checked every cycle.
module tb_wb_mgmt_mailbox;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] h2c_data;
  logic        h2c_valid;
  logic        h2c_ready = 1'b0;
  logic [31:0] c2h_data = '0;
  logic        c2h_valid = 1'b0;
  logic        c2h_ready;
  logic        core_rst_n;
  logic        irq;

  int total = 0;
  int bad   = 0;

  wb_mgmt_mailbox_if bus();

  wb_mgmt_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(bus),
    .h2c_data_o(h2c_data), .h2c_valid_o(h2c_valid), .h2c_ready_i(h2c_ready),
    .c2h_data_i(c2h_data), .c2h_valid_i(c2h_valid), .c2h_ready_o(c2h_ready),
    .core_rst_no(core_rst_n), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_h2c[$];
  logic [31:0] m_c2h[$];
  logic [1:0]  m_ctrl = '0;
  logic        m_ovf = 1'b0, m_udf = 1'b0, m_ack = 1'b0, m_irq = 1'b0;
  logic [31:0] m_dat = '0;
  logic [31:0] popq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    int h, c;
    logic [31:0] s;
    h = m_h2c.size();
    c = m_c2h.size();
    s = '0;
    s[0] = (h == DEPTH);
    s[1] = (h == 0);
    s[2] = (c == DEPTH);
    s[3] = (c == 0);
    s[4] = m_ovf;
    s[5] = m_udf;
    s[11:8]  = 4'(h);
    s[19:16] = 4'(c);
    return s;
  endfunction

  // Model: applies the register-map rules on each clock edge
  initial forever begin
    logic        acc, irq_n;
    logic [7:0]  off;
    logic [31:0] rd;
    int          h, c;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_h2c.delete(); m_c2h.delete();
      m_ctrl = '0; m_ovf = 0; m_udf = 0; m_ack = 0; m_irq = 0; m_dat = '0;
    end else begin
      acc = bus.wbs_cyc_i && bus.wbs_stb_i && (bus.wbs_adr_i[31:8] == BASE[31:8]) && !m_ack;
      off = bus.wbs_adr_i[7:0] & 8'hFC;
      h = m_h2c.size();
      c = m_c2h.size();
      rd = '0;
      if (acc && !bus.wbs_we_i) begin
        case (off)
          8'h00:   rd = {30'b0, m_ctrl};
          8'h04:   rd = m_status();
          8'h0C:   rd = (c > 0) ? m_c2h[0] : 32'h0;
          default: rd = '0;
        endcase
      end
      irq_n = m_ctrl[1] && (c > 0);
      if (h > 0 && h2c_ready) void'(m_h2c.pop_front());
      if (acc && bus.wbs_we_i) begin
        case (off)
          8'h00: if (bus.wbs_sel_i[0]) m_ctrl = bus.wbs_dat_i[1:0];
          8'h08: if (h < DEPTH) m_h2c.push_back(bus.wbs_dat_i); else m_ovf = 1;
          8'h10: begin
            if (bus.wbs_dat_i[4]) m_ovf = 0;
            if (bus.wbs_dat_i[5]) m_udf = 0;
          end
          default: ;
        endcase
      end
      if (acc && !bus.wbs_we_i && off == 8'h0C) begin
        if (c > 0) void'(m_c2h.pop_front()); else m_udf = 1;
      end
      if (c2h_valid && c < DEPTH) m_c2h.push_back(c2h_data);
      m_ack = acc;
      m_dat = rd;
      m_irq = irq_n;
    end
  end

  // Compare process, sampled mid-low-phase
  initial forever begin
    @(negedge clk);
    #1;
    chk("ack", 32'(bus.wbs_ack_o), 32'(m_ack));
    chk("rdata", bus.wbs_dat_o, m_dat);
    chk("irq", 32'(irq), 32'(m_irq));
    chk("core_rst_n", 32'(core_rst_n), 32'(m_ctrl[0]));
    chk("h2c_valid", 32'(h2c_valid), 32'(m_h2c.size() > 0));
    chk("c2h_ready", 32'(c2h_ready), 32'(m_c2h.size() < DEPTH));
    if (m_h2c.size() > 0) chk("h2c_data", h2c_data, m_h2c[0]);
    if (h2c_valid && h2c_ready) popq.push_back(h2c_data);
  end

  task automatic wb(input logic we_, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] rd, output int lat);
    @(negedge clk);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we_;
    bus.wbs_adr_i = a; bus.wbs_dat_i = d; bus.wbs_sel_i = s;
    lat = 0; rd = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        lat = n;
        rd  = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int lat;
    wb(1'b1, a, d, s, rd, lat);
    chk("wr_acked", 32'(lat != 0), 32'd1);
  endtask

  task automatic rdchk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    wb(1'b0, a, 32'h0, 4'hF, rd, lat);
    chk(nm, rd, exp);
  endtask

  task automatic core_push(input logic [31:0] d);
    @(negedge clk);
    c2h_valid = 1; c2h_data = d;
    @(negedge clk);
    c2h_valid = 0;
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = '0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_c2h_ready", 32'(c2h_ready), 32'd1);
    chk("rst_h2c_valid", 32'(h2c_valid), 32'd0);
    chk("rst_h2c_data", h2c_data, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    rdchk("rst_status", BASE + 32'h04, 32'h0000_000A);

    // CTRL byte-select handling and ack latency
    wb(1'b1, BASE, 32'h3, 4'h1, rd, lat);
    chk("ack_latency", 32'(lat), 32'd1);
    chk("core_run", 32'(core_rst_n), 32'd1);
    wr(BASE, 32'h0, 4'h2);
    rdchk("ctrl_sel_ignored", BASE, 32'h3);

    // H2C overflow
    h2c_ready = 0;
    for (int i = 1; i <= 5; i++) wr(BASE + 32'h08, 32'(i * 32'h11), 4'h0);
    rdchk("h2c_full_status", BASE + 32'h04, 32'h0000_0419);
    popq.delete();
    @(negedge clk); h2c_ready = 1;
    repeat (6) @(negedge clk);
    h2c_ready = 0;
    chk("h2c_pop_count", 32'(popq.size()), 32'd4);
    for (int i = 0; i < 4 && i < popq.size(); i++) chk("h2c_pop_order", popq[i], 32'((i + 1) * 32'h11));
    wr(BASE + 32'h10, 32'h10, 4'hF);
    rdchk("ovf_cleared", BASE + 32'h04, 32'h0000_000A);

    // C2H push raises irq two cycles later; read pops and drops it
    core_push(32'hDEAD_BEEF);
    chk("irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_high", 32'(irq), 32'd1);
    rdchk("c2h_read", BASE + 32'h0C, 32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    chk("irq_fell", 32'(irq), 32'd0);
    rdchk("c2h_underflow_read", BASE + 32'h0C, 32'h0);
    rdchk("udf_status", BASE + 32'h04, 32'h0000_002A);
    wr(BASE + 32'h10, 32'h20, 4'hF);
    rdchk("udf_cleared", BASE + 32'h04, 32'h0000_000A);

    // Simultaneous Wishbone pop and core push with one entry present
    core_push(32'h0000_0001);
    @(negedge clk);
    c2h_valid = 1; c2h_data = 32'h0000_0002;
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = BASE + 32'h0C;
    @(negedge clk);
    #1;
    chk("simul_ack", 32'(bus.wbs_ack_o), 32'd1);
    chk("simul_data", bus.wbs_dat_o, 32'h1);
    c2h_valid = 0; bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    rdchk("simul_status", BASE + 32'h04, 32'h0001_0002);
    rdchk("simul_second", BASE + 32'h0C, 32'h2);

    // Pointer wrap-around on both FIFOs
    for (int i = 0; i < 20; i++) begin
      core_push(32'hC000_0000 + 32'(i));
      rdchk("c2h_wrap", BASE + 32'h0C, 32'hC000_0000 + 32'(i));
    end
    popq.delete();
    h2c_ready = 1;
    for (int i = 0; i < 20; i++) wr(BASE + 32'h08, 32'hA000_0000 + 32'(i), 4'hF);
    repeat (3) @(negedge clk);
    h2c_ready = 0;
    chk("h2c_wrap_count", 32'(popq.size()), 32'd20);
    for (int i = 0; i < 20 && i < popq.size(); i++) chk("h2c_wrap_data", popq[i], 32'hA000_0000 + 32'(i));

    // Unmapped offset inside the window, and an address outside it
    rdchk("unmapped_read", BASE + 32'h14, 32'h0);
    wb(1'b0, BASE + 32'h100, 32'h0, 4'hF, rd, lat);
    chk("outside_no_ack", 32'(lat), 32'd0);

    // Reset during a pending access
    wr(BASE + 32'h08, 32'h77, 4'hF);
    @(negedge clk);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
    bus.wbs_adr_i = BASE; bus.wbs_dat_i = 32'h0; bus.wbs_sel_i = 4'h1;
    #2 rst_n = 0;
    @(negedge clk);
    #1;
    chk("reset_no_ack", 32'(bus.wbs_ack_o), 32'd0);
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("post_rst_core", 32'(core_rst_n), 32'd0);
    chk("post_rst_h2c_valid", 32'(h2c_valid), 32'd0);
    rdchk("post_rst_status", BASE + 32'h04, 32'h0000_000A);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
